// File: rtl/cache_mem_interface_pkg.sv
// Shared definitions for cache_mem_interface: FSM state encoding, command
// record layout {rw, block, addr} and buffer depth derivation.
package cache_mem_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int unsigned CMD_QUEUE_DEPTH = 2;

  function automatic int unsigned buf_depth(input int unsigned bw_block);
    return 1 << bw_block;
  endfunction

  // Command record is {rw, block, addr}; addr occupies the low bits.
  function automatic int unsigned cmd_width(input int unsigned bw_addr);
    return bw_addr + 2;
  endfunction

  function automatic int unsigned cmd_rw_bit(input int unsigned bw_addr);
    return bw_addr + 1;
  endfunction

  function automatic int unsigned cmd_block_bit(input int unsigned bw_addr);
    return bw_addr;
  endfunction

endpackage

// File: rtl/cache_mem_fifo.sv
// Small synchronous FIFO with registered storage and wrap-around pointers.
// An ack on a full (push) or empty (pop) side is ignored.
module cache_mem_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  output logic             push_ready_o,
  input  logic             push_ack_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_ready_o,
  input  logic             pop_ack_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    push_ready_o = (count_q != FULL);
    pop_ready_o  = (count_q != '0);
    do_push      = push_ack_i & push_ready_o;
    do_pop       = pop_ack_i & pop_ready_o;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d    = count_q + CNTW'(do_push) - CNTW'(do_pop);
    // Head reads as zero while empty so stale entries never leak out.
    pop_data_o = pop_ready_o ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cache_mem_interface.sv
// Memory-side stage below the cache controllers: queues block/word commands
// and runs them in order on a word-wide external port. Optional perf
// counters are enabled with CACHE_MEM_IF_PERF_EN.
module cache_mem_interface
  import cache_mem_interface_pkg::*;
#(
  parameter int unsigned BW_WORD_ADDR = 10,
  parameter int unsigned BW_BLOCK     = 2
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    mem_req_i,
  input  logic                    mem_req_block_i,
  input  logic                    mem_rw_i,
  input  logic [BW_WORD_ADDR-1:0] mem_addr_i,
  output logic                    mem_ready_o,
  output logic                    buffer_read_ready_o,
  output logic [31:0]             buffer_data_o,
  input  logic                    buffer_read_ack_i,
  output logic                    buffer_write_ready_o,
  input  logic [31:0]             buffer_data_i,
  input  logic                    buffer_write_ack_i,
  output logic                    ext_req_o,
  output logic                    ext_rw_o,
  output logic [BW_WORD_ADDR-1:0] ext_addr_o,
  output logic [31:0]             ext_data_o,
  input  logic                    ext_ack_i,
  input  logic [31:0]             ext_data_i,
  output logic                    cmd_overflow_o,
  output state_e                  state_dbg_o
`ifdef CACHE_MEM_IF_PERF_EN
  ,
  output logic [31:0]             perf_busy_cycles_o,
  output logic [31:0]             perf_stall_cycles_o
`endif
);

  localparam int unsigned CW        = cmd_width(BW_WORD_ADDR);
  localparam int unsigned RW_BIT    = cmd_rw_bit(BW_WORD_ADDR);
  localparam int unsigned BLK_BIT   = cmd_block_bit(BW_WORD_ADDR);
  localparam int unsigned BUF_DEPTH = buf_depth(BW_BLOCK);
  localparam int unsigned HW        = BW_WORD_ADDR - BW_BLOCK;
  localparam logic [BW_BLOCK:0] N_BLOCK = (BW_BLOCK + 1)'(BUF_DEPTH);
  localparam logic [BW_BLOCK:0] N_WORD  = (BW_BLOCK + 1)'(1);

  // Every port pair is a ready/ack handshake: a transfer happens in the cycle
  // where both ready and ack are 1; ack without ready is ignored.
  logic          cmd_pop_ready, cmd_pop;
  logic [CW-1:0] cmd_head;
  logic          rd_space, rd_push;
  logic          wr_avail, wr_pop;

  state_e                state_q, state_d;
  logic [BW_BLOCK:0]     cnt_q, cnt_d;
  logic [BW_BLOCK-1:0]   off_q, off_d;
  logic [HW-1:0]         base_q, base_d;
  logic                  ovf_q, ovf_d;

  cache_mem_fifo #(.WIDTH(CW), .DEPTH(CMD_QUEUE_DEPTH)) u_cmd_queue (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .push_ready_o (mem_ready_o),
    .push_ack_i   (mem_req_i),
    .push_data_i  ({mem_rw_i, mem_req_block_i, mem_addr_i}),
    .pop_ready_o  (cmd_pop_ready),
    .pop_ack_i    (cmd_pop),
    .pop_data_o   (cmd_head)
  );

  cache_mem_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_read_buf (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .push_ready_o (rd_space),
    .push_ack_i   (rd_push),
    .push_data_i  (ext_data_i),
    .pop_ready_o  (buffer_read_ready_o),
    .pop_ack_i    (buffer_read_ack_i),
    .pop_data_o   (buffer_data_o)
  );

  cache_mem_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_write_buf (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .push_ready_o (buffer_write_ready_o),
    .push_ack_i   (buffer_write_ack_i),
    .push_data_i  (buffer_data_i),
    .pop_ready_o  (wr_avail),
    .pop_ack_i    (wr_pop),
    .pop_data_o   (ext_data_o)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    base_d    = base_q;
    cmd_pop   = 1'b0;
    ext_req_o = 1'b0;
    rd_push   = 1'b0;
    wr_pop    = 1'b0;
    ovf_d     = ovf_q | (mem_req_i & ~mem_ready_o);
    case (state_q)
      ST_IDLE: begin
        if (cmd_pop_ready) begin
          cmd_pop = 1'b1;
          base_d  = cmd_head[BW_WORD_ADDR-1:BW_BLOCK];
          if (cmd_head[BLK_BIT]) begin
            cnt_d = N_BLOCK;
            off_d = '0;
          end else begin
            cnt_d = N_WORD;
            off_d = cmd_head[BW_BLOCK-1:0];
          end
          state_d = cmd_head[RW_BIT] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        // Requests are gated by buffer occupancy, which only this FSM can
        // reduce, so a raised request stays up until it is acked.
        ext_req_o = (state_q == ST_READ) ? rd_space : wr_avail;
        if (ext_req_o && ext_ack_i) begin
          rd_push = (state_q == ST_READ);
          wr_pop  = (state_q == ST_WRITE);
          off_d   = off_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == N_WORD) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ext_rw_o       = (state_q == ST_WRITE);
  assign ext_addr_o     = {base_q, off_q};
  assign cmd_overflow_o = ovf_q;
  assign state_dbg_o    = state_q;

`ifdef CACHE_MEM_IF_PERF_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (state_q != ST_IDLE && busy_q != '1) busy_d = busy_q + 1'b1;
    if (ext_req_o && !ext_ack_i && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cycles_o  = busy_q;
  assign perf_stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_cache_mem_interface.sv
// Directed bench for cache_mem_interface (BW_WORD_ADDR=10, BW_BLOCK=2) with a
// transaction scoreboard for the external port and one for read-buffer data.
module tb_cache_mem_interface;
  import cache_mem_interface_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned BB = 2;

  logic          clock_i = 1'b0;
  logic          resetn_i = 1'b0;
  logic          mem_req_i = 1'b0, mem_req_block_i = 1'b0, mem_rw_i = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic          mem_ready_o;
  logic          buffer_read_ready_o;
  logic [31:0]   buffer_data_o;
  logic          buffer_read_ack_i = 1'b0;
  logic          buffer_write_ready_o;
  logic [31:0]   buffer_data_i = '0;
  logic          buffer_write_ack_i = 1'b0;
  logic          ext_req_o, ext_rw_o;
  logic [AW-1:0] ext_addr_o;
  logic [31:0]   ext_data_o;
  logic          ext_ack_i = 1'b0;
  logic [31:0]   ext_data_i;
  logic          cmd_overflow_o;
  state_e        state_dbg;

  // External memory model: each word holds a tag plus its own address.
  assign ext_data_i = 32'hA5A5_0000 | {22'd0, ext_addr_o};

  cache_mem_interface #(.BW_WORD_ADDR(AW), .BW_BLOCK(BB)) dut (
    .clock_i              (clock_i),
    .resetn_i             (resetn_i),
    .mem_req_i            (mem_req_i),
    .mem_req_block_i      (mem_req_block_i),
    .mem_rw_i             (mem_rw_i),
    .mem_addr_i           (mem_addr_i),
    .mem_ready_o          (mem_ready_o),
    .buffer_read_ready_o  (buffer_read_ready_o),
    .buffer_data_o        (buffer_data_o),
    .buffer_read_ack_i    (buffer_read_ack_i),
    .buffer_write_ready_o (buffer_write_ready_o),
    .buffer_data_i        (buffer_data_i),
    .buffer_write_ack_i   (buffer_write_ack_i),
    .ext_req_o            (ext_req_o),
    .ext_rw_o             (ext_rw_o),
    .ext_addr_o           (ext_addr_o),
    .ext_data_o           (ext_data_o),
    .ext_ack_i            (ext_ack_i),
    .ext_data_i           (ext_data_i),
    .cmd_overflow_o       (cmd_overflow_o),
    .state_dbg_o          (state_dbg)
  );

  // Clock and watchdog
  always #5 clock_i = ~clock_i;

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, required $finish before it");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] rd_exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(negedge clock_i);
  endtask

  task automatic issue_cmd(input logic rw, input logic blk, input logic [AW-1:0] addr);
    mem_req_i       = 1'b1;
    mem_rw_i        = rw;
    mem_req_block_i = blk;
    mem_addr_i      = addr;
    step();
    mem_req_i       = 1'b0;
  endtask

  task automatic push_wb(input logic [31:0] data);
    buffer_write_ack_i = 1'b1;
    buffer_data_i      = data;
    step();
    buffer_write_ack_i = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_mem_ready",   mem_ready_o, 1);
    check("rst_rd_ready",    buffer_read_ready_o, 0);
    check("rst_wr_ready",    buffer_write_ready_o, 1);
    check("rst_ext_req",     ext_req_o, 0);
    check("rst_ext_rw",      ext_rw_o, 0);
    check("rst_ext_addr",    ext_addr_o, 0);
    check("rst_ext_data",    ext_data_o, 0);
    check("rst_buffer_data", buffer_data_o, 0);
    check("rst_overflow",    cmd_overflow_o, 0);
    check("rst_state",       state_dbg, ST_IDLE);
  endtask

  // Records accepted external words against exp_q, optionally pushing
  // writeback words into the write buffer during the first n_wb cycles.
  task automatic run_txns(input int cycles, input int n_wb, input logic [31:0] wb_base,
                          input int n_exp);
    int          seen;
    logic [63:0] obs;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i < n_wb) begin
        check("wb_ready", buffer_write_ready_o, 1);
        buffer_write_ack_i = 1'b1;
        buffer_data_i      = wb_base + i;
      end else begin
        buffer_write_ack_i = 1'b0;
      end
      if (ext_req_o && ext_ack_i) begin
        obs = {21'd0, ext_rw_o, ext_addr_o, ext_rw_o ? ext_data_o : 32'd0};
        seen++;
        if (exp_q.size() > 0) check("txn", obs, exp_q.pop_front());
      end
      step();
    end
    buffer_write_ack_i = 1'b0;
    check("txn_count", seen, n_exp);
  endtask

  task automatic drain(input int n, input int cycles);
    int got;
    got = 0;
    for (int i = 0; i < cycles; i++) begin
      if (buffer_read_ready_o && got < n) begin
        check("rd_data", buffer_data_o, rd_exp_q.pop_front());
        got++;
        buffer_read_ack_i = 1'b1;
      end else begin
        buffer_read_ack_i = 1'b0;
      end
      step();
    end
    buffer_read_ack_i = 1'b0;
    check("rd_count", got, n);
  endtask

  initial begin
    // Reset
    resetn_i = 1'b0;
    repeat (2) step();
    check_reset_values();
    resetn_i = 1'b1;
    step();

    // Block read from an unaligned address, memory always acks
    ext_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) rd_exp_q.push_back(32'hA5A5_0100 + i);
    issue_cmd(1'b0, 1'b1, 10'h103);
    check("t1_req_latency", ext_req_o, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_req", ext_req_o, 1);
      check("t1_addr", ext_addr_o, 10'h100 + i);
      check("t1_rw", ext_rw_o, 0);
      step();
    end
    check("t1_req_drop", ext_req_o, 0);
    check("t1_rd_ready", buffer_read_ready_o, 1);
    drain(4, 10);
    check("t1_rd_empty", buffer_read_ready_o, 0);

    // Single-word write with the request held while unacked
    ext_ack_i = 1'b0;
    push_wb(32'hDEAD_BEEF);
    issue_cmd(1'b1, 1'b0, 10'h3F5);
    check("t3_req_latency", ext_req_o, 0);
    step();
    check("t3_req", ext_req_o, 1);
    check("t3_addr", ext_addr_o, 10'h3F5);
    check("t3_rw", ext_rw_o, 1);
    check("t3_data", ext_data_o, 32'hDEAD_BEEF);
    step();
    check("t3_req_hold", ext_req_o, 1);
    check("t3_addr_hold", ext_addr_o, 10'h3F5);
    ext_ack_i = 1'b1;
    step();
    ext_ack_i = 1'b0;
    check("t3_req_done", ext_req_o, 0);
    check("t3_state_idle", state_dbg, ST_IDLE);
    step();
    check("t3_req_once", ext_req_o, 0);

    // Read then writeback back-to-back; writes only after the read finishes
    ext_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({21'd0, 1'b0, 10'(10'h040 + i), 32'd0});
      rd_exp_q.push_back(32'hA5A5_0040 + i);
    end
    for (int i = 0; i < 4; i++)
      exp_q.push_back({21'd0, 1'b1, 10'(10'h200 + i), 32'hC0DE_0000 + 32'(i)});
    issue_cmd(1'b0, 1'b1, 10'h040);
    check("t2_mem_ready_a", mem_ready_o, 1);
    issue_cmd(1'b1, 1'b1, 10'h200);
    check("t2_mem_ready_b", mem_ready_o, 1);
    run_txns(16, 4, 32'hC0DE_0000, 8);
    check("t2_wb_empty", ext_data_o, 0);
    drain(4, 10);

    // Two block reads with no buffer pops: the second one stalls
    ext_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) rd_exp_q.push_back(32'hA5A5_01C0 + i);
    for (int i = 0; i < 4; i++) rd_exp_q.push_back(32'hA5A5_02C0 + i);
    issue_cmd(1'b0, 1'b1, 10'h1C0);
    issue_cmd(1'b0, 1'b1, 10'h2C0);
    repeat (10) step();
    check("t4_req_stalled", ext_req_o, 0);
    check("t4_state_read", state_dbg, ST_READ);
    check("t4_rd_ready", buffer_read_ready_o, 1);
    check("t4_no_overflow", cmd_overflow_o, 0);
    drain(8, 40);
    check("t4_state_idle", state_dbg, ST_IDLE);

    // Queue overflow while the FSM is stuck on an unacked read
    ext_ack_i = 1'b0;
    issue_cmd(1'b0, 1'b0, 10'h010);
    issue_cmd(1'b0, 1'b0, 10'h011);
    issue_cmd(1'b0, 1'b0, 10'h012);
    check("t5_queue_full", mem_ready_o, 0);
    check("t5_no_overflow_yet", cmd_overflow_o, 0);
    issue_cmd(1'b0, 1'b0, 10'h013);
    check("t5_overflow", cmd_overflow_o, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({21'd0, 1'b0, 10'(10'h010 + i), 32'd0});
      rd_exp_q.push_back(32'hA5A5_0010 + i);
    end
    ext_ack_i = 1'b1;
    run_txns(12, 0, 32'd0, 3);
    check("t5_overflow_sticky", cmd_overflow_o, 1);
    drain(3, 8);

    // Reset in the middle of a block read
    ext_ack_i = 1'b0;
    push_wb(32'h1234_5678);
    ext_ack_i = 1'b1;
    issue_cmd(1'b0, 1'b1, 10'h080);
    repeat (3) step();
    check("t6_progress", ext_addr_o, 10'h082);
    check("t6_rd_ready", buffer_read_ready_o, 1);
    resetn_i  = 1'b0;
    ext_ack_i = 1'b0;
    step();
    check_reset_values();
    resetn_i = 1'b1;
    step();
    check("t6_stays_idle", state_dbg, ST_IDLE);
    check("t6_req_quiet", ext_req_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
